// File: rtl/instr_sequencer.sv
// picoMIPS multi-cycle sequencer: FETCH/DECODE/EXEC plus MUL_WAIT (multiplier handshake) and BAT_WAIT (switch stall).
// ALU/LDS/NOP retire in 3 cycles; MUL waits on mul_done, bounded by MUL_TIMEOUT; BAT holds until the debounced switch differs from bcond.
module instr_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MUL_TIMEOUT     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       bcond,
   input  logic       sw_raw,
   input  logic       mul_done,
   output logic       ir_load,
   output logic       pc_incr,
   output logic       rf_we,
   output logic       imm_sel,
   output logic       mul_start,
   output logic       mul_err,
   output logic       sw_stable,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_DECODE   = 3'd1,
      S_EXEC     = 3'd2,
      S_MUL_WAIT = 3'd3,
      S_BAT_WAIT = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SUBI = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_MULI = 4'b0101;
   localparam logic [3:0] OP_LDS  = 4'b0110;
   localparam logic [3:0] OP_BAT  = 4'b0111;

   localparam logic [7:0] TMO_LAST = 8'(MUL_TIMEOUT - 1);
   localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] tmo_q, tmo_d;
   logic [7:0] db_cnt_q, db_cnt_d;
   logic       mul_err_q, mul_err_d;
   logic       sw_stable_q, sw_stable_d;
   logic       sync1_q, sync2_q;
   logic       ir_load_c, pc_incr_c, rf_we_c, imm_sel_c, mul_start_c;

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      mul_err_d   = mul_err_q;
      ir_load_c   = 1'b0;
      pc_incr_c   = 1'b0;
      rf_we_c     = 1'b0;
      imm_sel_c   = 1'b0;
      mul_start_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_load_c = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            tmo_d = 8'd0;
            if (opcode == OP_MUL || opcode == OP_MULI) state_d = S_MUL_WAIT;
            else if (opcode == OP_BAT)                 state_d = S_BAT_WAIT;
            else                                       state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_incr_c = 1'b1;
            rf_we_c   = opcode inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_LDS};
            imm_sel_c = opcode inside {OP_ADDI, OP_SUBI};
            state_d   = S_FETCH;
         end
         S_MUL_WAIT: begin
            imm_sel_c   = (opcode == OP_MULI);
            mul_start_c = (tmo_q == 8'd0);
            // A result arriving on the last allowed cycle still retires normally.
            if (mul_done) begin
               rf_we_c   = 1'b1;
               pc_incr_c = 1'b1;
               state_d   = S_FETCH;
            end else if (tmo_q == TMO_LAST) begin
               mul_err_d = 1'b1;
               pc_incr_c = 1'b1;
               state_d   = S_FETCH;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_BAT_WAIT: begin
            if (sw_stable_q != bcond) begin
               pc_incr_c = 1'b1;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Debounce: a differing synchronised value must persist DEBOUNCE_CYCLES cycles.
   always_comb begin
      db_cnt_d    = 8'd0;
      sw_stable_d = sw_stable_q;
      if (sync2_q != sw_stable_q) begin
         if (db_cnt_q == DB_LAST) sw_stable_d = ~sw_stable_q;
         else                     db_cnt_d    = db_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FETCH;
         tmo_q       <= 8'd0;
         db_cnt_q    <= 8'd0;
         mul_err_q   <= 1'b0;
         sw_stable_q <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         db_cnt_q    <= db_cnt_d;
         mul_err_q   <= mul_err_d;
         sw_stable_q <= sw_stable_d;
         sync1_q     <= sw_raw;
         sync2_q     <= sync1_q;
      end
   end

   // Reset masks every output, so an abandoned instruction never retires.
   assign ir_load   = ir_load_c   & ~reset;
   assign pc_incr   = pc_incr_c   & ~reset;
   assign rf_we     = rf_we_c     & ~reset;
   assign imm_sel   = imm_sel_c   & ~reset;
   assign mul_start = mul_start_c & ~reset;
   assign mul_err   = mul_err_q   & ~reset;
   assign sw_stable = sw_stable_q & ~reset;
   assign state     = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle comparison of all outputs against hand-derived vectors.
module tb_instr_sequencer;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SUBI = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_MULI = 4'b0101;
   localparam logic [3:0] OP_LDS  = 4'b0110;
   localparam logic [3:0] OP_BAT  = 4'b0111;
   localparam logic [3:0] OP_NOP  = 4'b1111;
   localparam logic [3:0] OP_UND  = 4'b1010;

   logic       clk, reset, bcond, sw_raw, mul_done;
   logic [3:0] opcode;
   logic       ir_load, pc_incr, rf_we, imm_sel, mul_start, mul_err, sw_stable;
   logic [2:0] state;
   logic [9:0] obs_w;

   int n_checks = 0;
   int n_fail   = 0;
   int me       = 0;   // expected mul_err
   int ss       = 0;   // expected sw_stable

   instr_sequencer #(.DEBOUNCE_CYCLES(4), .MUL_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .sw_raw(sw_raw),
      .mul_done(mul_done), .ir_load(ir_load), .pc_incr(pc_incr), .rf_we(rf_we),
      .imm_sel(imm_sel), .mul_start(mul_start), .mul_err(mul_err),
      .sw_stable(sw_stable), .state(state)
   );

   assign obs_w = {state, ir_load, pc_incr, rf_we, imm_sel, mul_start, mul_err, sw_stable};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, ir_load, pc_incr, rf_we, imm_sel, mul_start, mul_err, sw_stable}
   function automatic logic [9:0] mk(input int st, input int il, input int pi, input int we,
                                     input int im, input int ms, input int m_e, input int s_s);
      return {st[2:0], il[0], pi[0], we[0], im[0], ms[0], m_e[0], s_s[0]};
   endfunction

   task automatic test_reset();
      logic [9:0] exp;
      reset = 1'b1; mul_done = 1'b1; opcode = OP_MUL; bcond = 1'b1; sw_raw = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         exp = 10'd0;
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL reset c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0; mul_done = 1'b0; bcond = 1'b0;
   endtask

   task automatic test_alu(input string nm, input logic [3:0] op, input int we, input int im);
      logic [9:0] exp;
      opcode = op;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         case (c)
            0:       exp = mk(0, 1, 0, 0,  0,  0, me, ss);
            1:       exp = mk(1, 0, 0, 0,  0,  0, me, ss);
            default: exp = mk(2, 0, 1, we, im, 0, me, ss);
         endcase
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL %s c%0d got %b exp %b", nm, c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // done_at: loop index at which mul_done is high for one cycle (-1 = never)
   task automatic test_mul(input string nm, input logic [3:0] op, input int im, input int done_at);
      logic [9:0] exp;
      bit fin, tmo;
      int mw;
      fin = 1'b0; tmo = 1'b0;
      opcode = op;
      for (int c = 0; c < 24 && !fin; c++) begin
         mul_done = (c == done_at);
         @(negedge clk);
         mw = c - 2;
         if (c == 0)                 exp = mk(0, 1, 0, 0, 0, 0, me, ss);
         else if (c == 1)            exp = mk(1, 0, 0, 0, 0, 0, me, ss);
         else if (c == done_at) begin
            exp = mk(3, 0, 1, 1, im, mw == 0, me, ss); fin = 1'b1;
         end else if (mw == 15) begin
            exp = mk(3, 0, 1, 0, im, 0, me, ss); fin = 1'b1; tmo = 1'b1;
         end else                    exp = mk(3, 0, 0, 0, im, mw == 0, me, ss);
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL %s c%0d got %b exp %b", nm, c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      mul_done = 1'b0;
      if (tmo) me = 1;
   endtask

   task automatic test_bat_debounce();
      logic [9:0] exp;
      opcode = OP_BAT; bcond = 1'b0; sw_raw = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         exp = (c == 0) ? mk(0, 1, 0, 0, 0, 0, me, 0) : mk(1, 0, 0, 0, 0, 0, me, 0);
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL bat_entry c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      // 3-cycle glitch must be filtered; steady high from c=10 releases 6 edges later
      for (int c = 0; c < 17; c++) begin
         sw_raw = (c < 3) || (c >= 10);
         @(negedge clk);
         exp = (c == 16) ? mk(4, 0, 1, 0, 0, 0, me, 1) : mk(4, 0, 0, 0, 0, 0, me, 0);
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL bat_wait c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      ss = 1;
   endtask

   task automatic test_bat_fast();
      logic [9:0] exp;
      opcode = OP_BAT; bcond = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         case (c)
            0:       exp = mk(0, 1, 0, 0, 0, 0, me, ss);
            1:       exp = mk(1, 0, 0, 0, 0, 0, me, ss);
            default: exp = mk(4, 0, 1, 0, 0, 0, me, ss);
         endcase
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL bat_fast c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [9:0] exp;
      opcode = OP_MUL; mul_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         case (c)
            0:       exp = mk(0, 1, 0, 0, 0, 0, me, ss);
            1:       exp = mk(1, 0, 0, 0, 0, 0, me, ss);
            2:       exp = mk(3, 0, 0, 0, 0, 1, me, ss);
            default: exp = mk(3, 0, 0, 0, 0, 0, me, ss);
         endcase
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL mid_mul c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      sw_raw = 1'b0; reset = 1'b1; mul_done = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs_w !== 10'd0) begin
         n_fail++; $display("FAIL mid_mul_reset got %b exp %b", obs_w, 10'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0; mul_done = 1'b0;
      me = 0; ss = 0;
   endtask

   task automatic test_reset_mid_bat();
      logic [9:0] exp;
      opcode = OP_BAT; bcond = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         case (c)
            0:       exp = mk(0, 1, 0, 0, 0, 0, 0, 0);
            1:       exp = mk(1, 0, 0, 0, 0, 0, 0, 0);
            default: exp = mk(4, 0, 0, 0, 0, 0, 0, 0);
         endcase
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++; $display("FAIL mid_bat c%0d got %b exp %b", c, obs_w, exp);
         end
         @(posedge clk); #1;
      end
      reset = 1'b1; bcond = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs_w !== 10'd0) begin
         n_fail++; $display("FAIL mid_bat_reset got %b exp %b", obs_w, 10'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0; bcond = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu("add",  OP_ADD,  1, 0);
      test_alu("addi", OP_ADDI, 1, 1);
      test_alu("sub",  OP_SUB,  1, 0);
      test_alu("subi", OP_SUBI, 1, 1);
      test_alu("lds",  OP_LDS,  1, 0);
      test_alu("nop",  OP_NOP,  0, 0);
      test_alu("undef", OP_UND, 0, 0);
      test_mul("muli_k4", OP_MULI, 1, 5);
      test_mul("mul_k1", OP_MUL, 0, 2);
      test_mul("mul_coincide", OP_MUL, 0, 17);
      test_mul("mul_timeout", OP_MUL, 0, -1);
      test_alu("add_after_err", OP_ADD, 1, 0);
      test_bat_debounce();
      test_bat_fast();
      test_reset_mid_mul();
      test_reset_mid_bat();
      test_alu("add_after_reset", OP_ADD, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
